interrupt_conditioner: RTL and testbench
========================================

INTERRUPT_CONDITIONER -- requirements
Module: interrupt_conditioner

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The parameters SHALL be:
- DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a level change; legal range 2..255.
- REISSUE_GAP, default 8: cycles between repeated pedestrian pulses while a request is unserved; legal range 2..255.

REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- police_btn  in  2  raw asynchronous police buttons; bit0 = first, bit1 = second.
- ped_btn  in  2  raw asynchronous pedestrian buttons; bit0 = first, bit1 = second.
- ped_served  in  2  synchronous one-cycle pulse from the downstream controller; the pedestrian lamp of that channel has turned green.
- first_police_interrupt  out  1  one-cycle pulse.
- second_police_interrupt  out  1  one-cycle pulse.
- first_pedestrian_interrupt  out  1  one-cycle pulse.
- second_pedestrian_interrupt  out  1  one-cycle pulse.
- ped_pending  out  2  high while the channel's pedestrian request is latched and unserved.

Function
REQ-004 Each of the 4 raw inputs SHALL pass through its own two-flop synchronizer before any other logic uses it.
REQ-005 Each channel SHALL have its own debouncer:
- State: a stable level and a counter.
- Counter increments each cycle the synchronized input differs from the stable level.
- Counter clears in any cycle the two agree.
- Stable level toggles, and the counter clears, in the cycle the counter would reach DEBOUNCE_CYCLES.

REQ-006 A stable-level 0->1 transition SHALL count as a press; a 1->0 transition SHALL generate nothing.
REQ-007 Police interrupts:
- Each police press SHALL produce exactly one registered one-cycle pulse on that channel's police output.
- Latency SHALL be DEBOUNCE_CYCLES+3 clock edges from the first edge that samples the raw input high.

REQ-008 Both police presses in the same cycle SHALL both pulse in that cycle.
REQ-009 Each pedestrian channel SHALL run an independent FSM with states IDLE, ISSUE and WAIT; ped_pending SHALL be high in ISSUE and WAIT.
REQ-010 IDLE: a press SHALL move the FSM to ISSUE; ped_served SHALL be ignored in IDLE.
REQ-011 ISSUE: the FSM SHALL drive a one-cycle pedestrian pulse and move to WAIT with the gap counter cleared, except:
- If either police pulse is asserted in that cycle, the pedestrian pulse SHALL be withheld and the FSM SHALL stay in ISSUE.
- If ped_served is high, the FSM SHALL go to IDLE with no pulse.

REQ-012 WAIT: the gap counter SHALL increment each cycle, with transitions as follows:
- ped_served high SHALL move the FSM to IDLE; this has priority over the gap expiry.
- The counter reaching REISSUE_GAP-1 SHALL move the FSM to ISSUE.

REQ-013 A new press while in ISSUE or WAIT SHALL be merged: no additional state and no additional pulse.
REQ-014 The pedestrian latency from an accepted press in IDLE with no police activity SHALL be DEBOUNCE_CYCLES+4 edges, one more than police because of the ISSUE stage.
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 Counter widths SHALL hold parameter maximums without wrap; counters SHALL saturate-clear as specified and never wrap silently.

Reset
REQ-017 While rst is high, the following SHALL hold regardless of clk:
- All synchronizer flops, stable levels and counters are 0.
- All FSMs are in IDLE.
- All interrupt outputs and ped_pending are 0.

REQ-018 Asserting rst mid-operation SHALL discard pending requests and in-flight debounce progress.
REQ-019 After rst deasserts, a button still held SHALL be treated as a fresh press (stable level was reset to 0) and pulse after the normal latency.

Verification (DEBOUNCE_CYCLES=4, REISSUE_GAP=8)
REQ-020 Police press: police_btn[0] raised and held -> first_police_interrupt high for exactly 1 cycle, 7 edges after first sample; no further pulse while held; release -> no pulse.
REQ-021 Bounce rejection: ped_btn[1] toggling every 2 cycles for 20 cycles, then low -> no pedestrian pulse, ped_pending stays 0.
REQ-022 Reissue and serve: ped_btn[0] press with ped_served never asserted -> pulses at edges 8, 16, 24 (period 8), ped_pending high throughout; ped_served[0] pulse -> ped_pending[0] low next cycle and no further pulses.
REQ-023 Police priority: a police press timed to land in the same cycle as a pedestrian ISSUE -> police pulse in that cycle, pedestrian pulse exactly 1 cycle later; both police channels simultaneous -> both pulse the same cycle.
REQ-024 Reset mid-request: ped_pending[1]=1, rst pulsed for 3 cycles with ped_btn[1] held -> all outputs 0 during rst; after release a pedestrian pulse 8 edges later.
REQ-025 Merge: a second ped_btn[0] press during WAIT -> pulse cadence unchanged (no extra pulse).

Source files
------------

// File: rtl/interrupt_conditioner.sv
// Turns raw police/pedestrian buttons into synchronized, debounced one-cycle interrupts.
// Pedestrian requests stay latched and are reissued until the controller reports them served.
module interrupt_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REISSUE_GAP     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] police_btn,
    input  logic [1:0] ped_btn,
    input  logic [1:0] ped_served,
    output logic       first_police_interrupt,
    output logic       second_police_interrupt,
    output logic       first_pedestrian_interrupt,
    output logic       second_pedestrian_interrupt,
    output logic [1:0] ped_pending
);
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    // WAIT hands over one cycle early so that the ISSUE cycle completes the gap
    localparam logic [7:0] GAP_LAST = 8'(REISSUE_GAP - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [3:0] w_raw;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_stable;
    logic [3:0] r_stable_d;
    logic [7:0] r_deb_cnt [4];
    logic [3:0] w_press;
    logic       w_police_any;
    logic [1:0] r_police;
    logic [1:0] w_ped_int;
    logic [1:0] w_pend;

    // channels 0/1 are police, 2/3 are pedestrian
    assign w_raw = {ped_btn, police_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable   <= 4'b0000;
            r_stable_d <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_deb_cnt[i] <= 8'd0;
            end
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_stable[i]  <= ~r_stable[i];
                        r_deb_cnt[i] <= 8'd0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                    end
                end else begin
                    r_deb_cnt[i] <= 8'd0;
                end
            end
        end
    end

    // A press is a rise of the stable level; it is high for the cycle after the toggle
    assign w_press      = r_stable & ~r_stable_d;
    assign w_police_any = w_press[0] | w_press[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_police <= 2'b00;
        end else begin
            r_police <= w_press[1:0];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ped
        state_t     r_state;
        state_t     w_state_next;
        logic [7:0] r_gap;
        logic [7:0] w_gap_next;
        logic       w_pulse_next;
        logic       w_pend_next;
        logic       r_pulse;
        logic       r_pend;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_gap   <= 8'd0;
            end else begin
                r_state <= w_state_next;
                r_gap   <= w_gap_next;
            end
        end

        always_comb begin
            w_state_next = r_state;
            w_gap_next   = r_gap;
            case (r_state)
                S_IDLE: begin
                    if (w_press[2 + g]) begin
                        w_state_next = S_ISSUE;
                        w_gap_next   = 8'd0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (ped_served[g]) begin
                        w_state_next = S_IDLE;
                    end else if (w_police_any) begin
                        // police pulses in the next cycle; hold so the outputs never coincide
                        w_state_next = S_ISSUE;
                    end else begin
                        w_state_next = S_WAIT;
                        w_gap_next   = 8'd0;
                    end
                end
                S_WAIT: begin
                    if (ped_served[g]) begin
                        w_state_next = S_IDLE;
                    end else if (r_gap == GAP_LAST) begin
                        w_state_next = S_ISSUE;
                    end else begin
                        w_gap_next = r_gap + 8'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_gap_next   = 8'd0;
                end
            endcase
        end

        always_comb begin
            w_pulse_next = 1'b0;
            if ((r_state == S_ISSUE) && !ped_served[g] && !w_police_any) begin
                w_pulse_next = 1'b1;
            end else begin
                w_pulse_next = 1'b0;
            end
            w_pend_next = (w_state_next != S_IDLE);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pulse <= 1'b0;
                r_pend  <= 1'b0;
            end else begin
                r_pulse <= w_pulse_next;
                r_pend  <= w_pend_next;
            end
        end

        assign w_ped_int[g] = r_pulse;
        assign w_pend[g]    = r_pend;
    end

    assign first_police_interrupt      = r_police[0];
    assign second_police_interrupt     = r_police[1];
    assign first_pedestrian_interrupt  = w_ped_int[0];
    assign second_pedestrian_interrupt = w_ped_int[1];
    assign ped_pending                 = w_pend;

endmodule

// File: tb/tb_interrupt_conditioner.sv
// Self-checking bench: vector table, directed corner sequences and random stimulus
// compared against a window/schedule based reference model.
module tb_interrupt_conditioner;
    localparam int DEB = 4;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] police_btn = 2'b00;
    logic [1:0] ped_btn    = 2'b00;
    logic [1:0] ped_served = 2'b00;
    logic       fp, sp, fped, sped;
    logic [1:0] pend;

    int n_vec = 0;
    int n_err = 0;

    interrupt_conditioner #(.DEBOUNCE_CYCLES(DEB), .REISSUE_GAP(GAP)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .police_btn                  (police_btn),
        .ped_btn                     (ped_btn),
        .ped_served                  (ped_served),
        .first_police_interrupt      (fp),
        .second_police_interrupt     (sp),
        .first_pedestrian_interrupt  (fped),
        .second_pedestrian_interrupt (sped),
        .ped_pending                 (pend)
    );

    always #5 clk = ~clk;

    // reference model: raw sample history, accepted levels and pedestrian schedules
    logic       m_hist [4][0:15];
    logic [3:0] m_stable;
    logic [3:0] m_rose;
    logic [1:0] m_pol;
    logic [1:0] m_pend;
    logic [1:0] m_pulse;
    int         m_due [2];
    int         m_edge;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 16; k++)
                m_hist[c][k] = 1'b0;
        m_stable = 4'b0000;
        m_rose   = 4'b0000;
        m_pol    = 2'b00;
        m_pend   = 2'b00;
        m_pulse  = 2'b00;
        m_due[0] = 0;
        m_due[1] = 0;
        m_edge   = 0;
    endfunction

    function automatic void model_edge();
        logic [3:0] raw;
        logic [3:0] rose_now;
        logic       all_diff;
        raw = {ped_btn, police_btn};
        m_edge++;
        for (int c = 0; c < 4; c++) begin
            for (int k = DEB + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
            m_hist[c][0] = raw[c];
            // level accepted once the DEB samples seen through the synchronizer all differ
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (m_hist[c][k] == m_stable[c]) all_diff = 1'b0;
            rose_now[c] = 1'b0;
            if (all_diff) begin
                m_stable[c] = ~m_stable[c];
                rose_now[c] = m_stable[c];
            end
        end
        for (int c = 0; c < 2; c++) begin
            m_pulse[c] = 1'b0;
            if (!m_pend[c]) begin
                if (m_rose[2+c]) begin
                    m_pend[c] = 1'b1;
                    m_due[c]  = m_edge + 1;
                end
            end else if (ped_served[c]) begin
                m_pend[c] = 1'b0;
            end else if (m_edge == m_due[c]) begin
                if (m_rose[0] || m_rose[1]) begin
                    m_due[c] = m_edge + 1;
                end else begin
                    m_pulse[c] = 1'b1;
                    m_due[c]   = m_edge + GAP;
                end
            end
        end
        m_pol  = m_rose[1:0];
        m_rose = rose_now;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk_vec("model", {fp, sp, fped, sped, pend},
                {m_pol[0], m_pol[1], m_pulse[0], m_pulse[1], m_pend[1], m_pend[0]});
    endtask

    task automatic hit_reset(input int cycles);
        #2 rst = 1'b1;
        model_reset();
        #1 chk_vec("reset_async", {fp, sp, fped, sped, pend}, 6'b000000);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk_vec("reset_held", {fp, sp, fped, sped, pend}, 6'b000000);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic do_reset();
        police_btn = 2'b00;
        ped_btn    = 2'b00;
        ped_served = 2'b00;
        hit_reset(3);
    endtask

    typedef struct {
        logic [1:0] pol;
        logic [1:0] ped;
        logic [1:0] srv;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [70];

    initial begin
        // exp bit order: {fp, sp, fped, sped, pend[1], pend[0]}
        for (int r = 0; r < 70; r++) begin
            tbl[r].pol = 2'b00;
            tbl[r].ped = 2'b00;
            tbl[r].srv = 2'b00;
            tbl[r].exp = 6'b000000;
        end
        for (int r = 0; r < 12; r++)  tbl[r].pol = 2'b01;
        tbl[6].exp = 6'b100000;
        for (int r = 24; r < 34; r++) tbl[r].pol = 2'b11;
        tbl[30].exp = 6'b110000;
        for (int r = 46; r < 70; r++) tbl[r].ped = 2'b10;
        for (int r = 52; r < 64; r++) tbl[r].exp = 6'b000010;
        tbl[53].exp = 6'b000110;
        tbl[61].exp = 6'b000110;
        tbl[64].srv = 2'b10;

        model_reset();
        do_reset();

        for (int r = 0; r < 70; r++) begin
            police_btn = tbl[r].pol;
            ped_btn    = tbl[r].ped;
            ped_served = tbl[r].srv;
            tick();
            chk_vec("table", {fp, sp, fped, sped, pend}, tbl[r].exp);
        end

        // bouncing pedestrian input never settles long enough
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ped_btn[1] = (i < 20) ? ~i[1] : 1'b0;
            tick();
            chk_bit("bounce_pulse", sped, 1'b0);
            chk_bit("bounce_pend", pend[1], 1'b0);
        end

        // reissue cadence, merged second press, then serve
        do_reset();
        ped_btn = 2'b01;
        for (int e = 1; e <= 34; e++) begin
            if (e == 10) ped_btn = 2'b00;
            if (e == 16) ped_btn = 2'b01;
            tick();
            chk_bit("reissue_pulse", fped, (e == 8 || e == 16 || e == 24 || e == 32));
            chk_bit("reissue_pend", pend[0], (e >= 7));
        end
        ped_served = 2'b01;
        tick();
        chk_bit("serve_pend", pend[0], 1'b0);
        ped_served = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_bit("served_quiet", fped, 1'b0);
            chk_bit("served_pend", pend[0], 1'b0);
        end

        // police press lands in the pedestrian ISSUE cycle
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            if (e == 1) ped_btn = 2'b01;
            if (e == 2) police_btn = 2'b01;
            tick();
            chk_bit("prio_police", fp, (e == 8));
            chk_bit("prio_ped", fped, (e == 9 || e == 17));
        end

        // reset while a request is pending, button still held
        do_reset();
        ped_btn = 2'b10;
        for (int e = 1; e <= 10; e++) tick();
        chk_bit("pre_rst_pend", pend[1], 1'b1);
        hit_reset(3);
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk_bit("post_rst_ped", sped, (e == 8));
            chk_bit("post_rst_pend", pend[1], (e >= 7));
        end

        // random stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 9) == 0) police_btn[b] = ~police_btn[b];
                if ($urandom_range(0, 9) == 0) ped_btn[b] = ~ped_btn[b];
                ped_served[b] = ($urandom_range(0, 29) == 0);
            end
            if (i == 1500) hit_reset(2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
